// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data and occupancy flags.
// Latency: a write is readable one edge after it is accepted; data_out loads on the read edge.
// Backpressure: writes are dropped while full and reads are ignored while empty, with optional sticky error flags.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   cs, wr_en, rd_en          chip select and requests (requests ignored while cs is low)
//   data_in / data_out        write data / registered read data (held between reads)
//   full, empty               occupancy == DEPTH / occupancy == 0
//   almost_full/almost_empty  occupancy >= AF_THRESH / occupancy <= AE_THRESH
//   count                     occupancy, 0..DEPTH
//   err_clr, overflow, underflow
//                             sticky rejected-write / rejected-read flags and their clear.
//                             They are live only when SYNC_FIFO_ERR_EN is defined; otherwise
//                             they are tied to 0 and err_clr is ignored.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

    // Storage is deliberately left out of reset; only pointers and count define validity.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Flags decode straight from the count register so they never lag it.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign data_out     = data_out_q;

    // Acceptance uses pre-edge full/empty, so full+both is a read and empty+both is a write.
    assign wr_acc = cs && wr_en && !full;
    assign rd_acc = cs && rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = mem[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef SYNC_FIFO_ERR_EN
    // Clear first, then set, so a same-cycle set condition wins over err_clr.
    // Error tracking is independent of acceptance: any request against a full/empty FIFO counts.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (cs && wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (cs && rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_comb begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
    end
`endif

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Reset outranks a concurrent write; the entry would be invalid anyway.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the entry count; it is a power of two and at least 4.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, meaning the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_THRESH, default 2, meaning the occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (CNT_W = clog2(DEPTH)+1):
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- cs  input  1  chip select; when low, wr_en and rd_en are ignored.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  DATA_W  write data.
- err_clr  input  1  clears the sticky error flags.
- data_out  output  DATA_W  registered read data.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- almost_full  output  1  occupancy >= AF_THRESH.
- almost_empty  output  1  occupancy <= AE_THRESH.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was rejected.
- underflow  output  1  sticky flag: a read was rejected.

Function
REQ-006 A write SHALL be accepted when cs && wr_en && !full, as sampled before the edge; data_in is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-007 A read SHALL be accepted when cs && rd_en && !empty; the entry at rd_ptr loads data_out at that edge (1-cycle latency), and rd_ptr increments modulo DEPTH.
REQ-008 data_out SHALL hold its value on every cycle without an accepted read.
REQ-009 count SHALL change by +1 for a write-only acceptance, -1 for a read-only acceptance, and 0 when both or neither are accepted.
REQ-010 When full and both wr_en and rd_en are asserted, the read SHALL be accepted, the write rejected, and count becomes DEPTH-1.
REQ-011 When empty and both wr_en and rd_en are asserted, the write SHALL be accepted, the read rejected, data_out held, and count becomes 1.
REQ-012 full, empty, almost_full and almost_empty SHALL be pure decodes of the count register, with no additional latency relative to count.
REQ-013 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entries.
REQ-014 FIFO ordering SHALL be strict first-in, first-out.
REQ-015 With cs low, no state SHALL change except error clearing through err_clr.

Reset
REQ-016 While rst is high at a clock edge, the block SHALL set wr_ptr, rd_ptr, count, data_out, overflow and underflow to 0; full and almost_full read 0, empty and almost_empty read 1.
REQ-017 Reset SHALL take priority over every concurrent request; in-flight contents are discarded.
REQ-018 Storage array contents SHALL NOT be reset.

Configuration
REQ-019 When macro SYNC_FIFO_ERR_EN is defined, overflow SHALL set on cs && wr_en && full, and underflow SHALL set on cs && rd_en && empty.
REQ-020 When SYNC_FIFO_ERR_EN is defined, both flags SHALL stay set until a cycle with err_clr high; if a set condition and err_clr occur in the same cycle, the set wins.
REQ-021 When SYNC_FIFO_ERR_EN is undefined, overflow and underflow SHALL remain present as ports, tied to 0, and err_clr SHALL be ignored.

Verification (DATA_W=32, DEPTH=16, defaults)
REQ-022 Assert rst for 2 cycles, then release -> count=0, empty=1, almost_empty=1, full=0, data_out=0.
REQ-023 Write 0x1..0x10 back-to-back -> count=16, full=1, almost_full set when count reaches 14; 16 reads return 0x1..0x10 in order, each one cycle after its read, ending with empty=1.
REQ-024 Fill to 16, then a 17th write of 0xDEAD -> write rejected, count=16, overflow=1 (macro defined) or 0 (undefined); contents unchanged.
REQ-025 Hold count at 8 and run 40 cycles of simultaneous wr/rd with an incrementing pattern -> count stays 8, pointers wrap twice, output order is intact.
REQ-026 Assert rd_en+wr_en while empty -> count=1, data_out held; assert rd_en+wr_en while full -> count=15.
REQ-027 Assert rst at count=10 mid-burst -> the next cycle shows count=0, empty=1, and prior data is not readable; with the macro defined, err_clr asserted together with an overflow condition leaves overflow=1.
